// File: rtl/pwm_drive_16_if.sv
// Command/status bundle between the PID back end and the PWM drive.
interface pwm_drive_16_if;
    logic        enable;
    logic [15:0] period;
    logic [15:0] cmd;
    logic [3:0]  cmd_shift;
    logic        pwm;
    logic        dir;
    logic [16:0] duty;
    logic        period_start;
    logic        in_deadtime;

    // The controller side drives commands and observes the drive status.
    modport master (
        output enable, period, cmd, cmd_shift,
        input  pwm, dir, duty, period_start, in_deadtime
    );

    // The PWM drive consumes commands and produces the status.
    modport slave (
        input  enable, period, cmd, cmd_shift,
        output pwm, dir, duty, period_start, in_deadtime
    );
endinterface

// File: rtl/pwm_drive_16.sv
// Signed 16-bit command to PWM + direction for an H-bridge, with commands
// latched at period boundaries and a whole-period dead-time on reversal.
module pwm_drive_16 #(
    parameter int unsigned DEAD_PERIODS = 2  // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    pwm_drive_16_if.slave     bus
);

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  dead_cnt;
    logic [3:0]  dead_cnt_next;
    logic [15:0] cnt;
    logic [15:0] period_active;
    logic        dir_next;
    logic [16:0] duty_next;
    logic        boundary;
    logic        run;

    logic [15:0] cmd_neg;
    logic [16:0] mag;
    logic [16:0] mag_s;
    logic [16:0] period_len;
    logic [16:0] req_duty;
    logic        req_dir;
    logic        apply_run;

    assign boundary = (cnt == period_active);
    assign cmd_neg  = ~bus.cmd + 16'd1;

    // Command conditioning: magnitude, shift, clamp to the incoming period.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        mag = '0;
        if (bus.cmd == 16'h8000) begin
            mag = 17'd32767;                 // -32768 saturates to +32767
        end else if (bus.cmd[15]) begin
            mag = {1'b0, cmd_neg};
        end else begin
            mag = {1'b0, bus.cmd};
        end
        mag_s      = mag >> bus.cmd_shift;
        period_len = {1'b0, bus.period} + 17'd1;
        req_duty   = (mag_s < period_len) ? mag_s : period_len;
        // A zero command carries no direction request: keep the current one.
        req_dir    = (bus.cmd == 16'd0) ? bus.dir : bus.cmd[15];
    end

    // State register: interlock state and remaining dead periods.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and every flop has a reset value, so
        // reset wins even mid-period or mid-deadtime.
        if (!rst) begin
            state    <= RUN;
            dead_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops
            // update together from the pre-edge values.
            state    <= state_next;
            dead_cnt <= dead_cnt_next;
        end
    end

    // Next-state logic: only a period boundary may change dir/duty/state.
    always_comb begin
        state_next    = state;
        dead_cnt_next = dead_cnt;
        dir_next      = bus.dir;
        duty_next     = bus.duty;
        apply_run     = 1'b0;
        if (boundary) begin
            case (state)
                RUN:  apply_run = 1'b1;
                DEAD: begin
                    dead_cnt_next = dead_cnt - 4'd1;
                    // Last dead period ends here; evaluate this boundary's cmd.
                    if (dead_cnt == 4'd1) apply_run = 1'b1;
                end
                default: apply_run = 1'b1;
            endcase
        end
        if (apply_run) begin
            if ((req_duty != 17'd0) && (req_dir != bus.dir)) begin
                // Reversal: force the bridge off for whole periods first.
                dir_next      = req_dir;
                duty_next     = '0;
                dead_cnt_next = 4'(DEAD_PERIODS);
                state_next    = DEAD;
            end else begin
                duty_next  = req_duty;
                state_next = RUN;
            end
        end
    end

    // Output decode from the registered state.
    always_comb begin
        run             = (state == RUN);
        bus.in_deadtime = (state == DEAD);
    end

    // Counter, boundary latching and the registered PWM output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt              <= '0;
            period_active    <= '0;
            bus.dir          <= 1'b0;
            bus.duty         <= '0;
            bus.period_start <= 1'b0;
            bus.pwm          <= 1'b0;
        end else begin
            if (boundary) begin
                cnt           <= '0;
                period_active <= bus.period;
            end else begin
                cnt <= cnt + 16'd1;
            end
            bus.dir          <= dir_next;
            bus.duty         <= duty_next;
            bus.period_start <= boundary;
            bus.pwm          <= bus.enable & run & ({1'b0, cnt} < bus.duty);
        end
    end

endmodule

// File: tb/tb_pwm_drive_16.sv
// Directed self-checking bench for pwm_drive_16 (DEAD_PERIODS = 2).
module tb_pwm_drive_16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   hi, ps, first, hi2, ps2, first2;

    pwm_drive_16_if bus ();

    pwm_drive_16 #(.DEAD_PERIODS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance n clocks, counting pwm-high and period_start cycles and the
    // first step index at which pwm is high (0 if never).
    task automatic window(input int n, output int h, output int p, output int f);
        h = 0; p = 0; f = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (bus.pwm === 1'b1) begin
                h++;
                if (f == 0) f = i;
            end
            if (bus.period_start === 1'b1) p++;
        end
    endtask

    task automatic check_status(input string tag, input logic [16:0] duty_e,
                                input logic dir_e, input logic dt_e);
        check({tag, ".duty"}, bus.duty, duty_e);
        check({tag, ".dir"}, bus.dir, dir_e);
        check({tag, ".in_deadtime"}, bus.in_deadtime, dt_e);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b0;
        bus.enable    = 1'b1;
        bus.period    = 16'd99;
        bus.cmd       = 16'd50;
        bus.cmd_shift = 4'd0;

        // Reset state
        step(2);
        check("rst.pwm", bus.pwm, 1'b0);
        check("rst.period_start", bus.period_start, 1'b0);
        check_status("rst", 17'd0, 1'b0, 1'b0);

        // Scenario 1: first boundary one cycle after release
        rst = 1'b1;
        step(1);
        check("s1.first_boundary", bus.period_start, 1'b1);
        check("s1.pwm_at_boundary", bus.pwm, 1'b0);
        check_status("s1", 17'd50, 1'b0, 1'b0);
        window(100, hi, ps, first);
        check("s1.hi", hi, 50);
        check("s1.ps", ps, 1);
        check("s1.first", first, 1);
        window(100, hi, ps, first);
        check("s1.hi2", hi, 50);
        check("s1.ps2", ps, 1);

        // Scenario 3: reversal mid-period -> 2 dead periods
        window(30, hi, ps, first);
        bus.cmd = -16'sd30;
        window(70, hi2, ps2, first2);
        check("s3.completes_at_50", hi + hi2, 50);
        check("s3.boundary", bus.period_start, 1'b1);
        check_status("s3.dead", 17'd0, 1'b1, 1'b1);
        window(100, hi, ps, first);
        check("s3.dead1_hi", hi, 0);
        check_status("s3.dead2", 17'd0, 1'b1, 1'b1);
        window(100, hi, ps, first);
        check("s3.dead2_hi", hi, 0);
        check_status("s3.run", 17'd30, 1'b1, 1'b0);
        window(100, hi, ps, first);
        check("s3.hi30", hi, 30);
        check("s3.first", first, 1);

        // Scenario 2: -32768 >> 4 clamps to period+1, same direction
        bus.cmd       = 16'h8000;
        bus.cmd_shift = 4'd4;
        window(100, hi, ps, first);
        check("s2.old_period_hi", hi, 30);
        check_status("s2", 17'd100, 1'b1, 1'b0);
        window(100, hi, ps, first);
        check("s2.full_hi", hi, 100);
        check("s2.pwm_at_boundary", bus.pwm, 1'b1);
        window(100, hi, ps, first);
        check("s2.full_hi2", hi, 100);
        bus.cmd_shift = 4'd0;

        // Scenario 4: back to +50 (reversal), then zero, then -10
        bus.cmd = 16'd50;
        window(100, hi, ps, first);
        check("s4.pre_hi", hi, 100);
        check_status("s4.dead", 17'd0, 1'b0, 1'b1);
        window(100, hi, ps, first);
        window(100, hi, ps, first);
        check_status("s4.run50", 17'd50, 1'b0, 1'b0);
        bus.cmd = 16'd0;
        window(100, hi, ps, first);
        check("s4.last50_hi", hi, 50);
        check_status("s4.zero1", 17'd0, 1'b0, 1'b0);
        window(100, hi, ps, first);
        check("s4.zero_hi", hi, 0);
        window(100, hi, ps, first);
        check_status("s4.zero3", 17'd0, 1'b0, 1'b0);
        bus.cmd = -16'sd10;
        window(100, hi, ps, first);
        check_status("s4.neg_dead", 17'd0, 1'b1, 1'b1);
        window(100, hi, ps, first);
        check("s4.neg_dead_mid", bus.in_deadtime, 1'b1);
        window(100, hi, ps, first);
        check_status("s4.neg_run", 17'd10, 1'b1, 1'b0);
        bus.cmd = 16'd0;
        window(100, hi, ps, first);
        check("s4.hi10", hi, 10);
        check_status("s4.zero_held", 17'd0, 1'b1, 1'b0);
        bus.cmd = -16'sd10;
        window(100, hi, ps, first);
        check_status("s4.same_sign_no_dead", 17'd10, 1'b1, 1'b0);

        // Scenario 5: enable dropped 10 clocks into the high phase
        bus.cmd = -16'sd50;
        window(100, hi, ps, first);
        check("s5.pre_hi", hi, 10);
        check("s5.duty", bus.duty, 17'd50);
        window(10, hi, ps, first);
        check("s5.hi_before_drop", hi, 10);
        bus.enable = 1'b0;
        window(1, hi, ps, first);
        check("s5.pwm_off_next", hi, 0);
        window(9, hi, ps, first);
        check("s5.off_hi", hi, 0);
        check("s5.off_ps", ps, 0);
        bus.enable = 1'b1;
        window(80, hi, ps, first);
        check("s5.resume_first", first, 1);
        check("s5.resume_hi", hi, 30);
        check("s5.boundary_kept", bus.period_start, 1'b1);
        check("s5.ps_count", ps, 1);

        // Scenario 6: dead-time re-entry, then reset mid-deadtime
        bus.cmd = 16'd40;
        window(100, hi, ps, first);
        check("s6.pre_hi", hi, 50);
        check_status("s6.dead_fwd", 17'd0, 1'b0, 1'b1);
        bus.cmd = -16'sd40;
        window(100, hi, ps, first);
        window(100, hi, ps, first);
        check_status("s6.reenter", 17'd0, 1'b1, 1'b1);
        window(37, hi, ps, first);
        rst     = 1'b0;
        bus.cmd = 16'd50;
        step(1);
        check("s6.rst.pwm", bus.pwm, 1'b0);
        check("s6.rst.period_start", bus.period_start, 1'b0);
        check_status("s6.rst", 17'd0, 1'b0, 1'b0);
        step(1);
        rst = 1'b1;
        step(1);
        check("s6.first_boundary", bus.period_start, 1'b1);
        check_status("s6.after", 17'd50, 1'b0, 1'b0);
        window(100, hi, ps, first);
        check("s6.hi", hi, 50);
        check("s6.first", first, 1);
        check("s6.ps", ps, 1);

        // Period change to 0: takes effect at the boundary, duty clamps to 1
        bus.period = 16'd0;
        window(100, hi, ps, first);
        check("p0.old_period_hi", hi, 50);
        check("p0.duty_clamped", bus.duty, 17'd1);
        window(5, hi, ps, first);
        check("p0.ps_continuous", ps, 5);
        check("p0.pwm_continuous", hi, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
